// File: rtl/acc_pkg.sv
// Shared types and lane constants for the accumulator sequencer.
// Lane width is fixed here; the vector width of acc_ctrl derives from it.
package acc_pkg;

    localparam int ELEM_WIDTH = 24;
    localparam int LANES      = 16;

    localparam logic [ELEM_WIDTH-1:0] SAT_MAX = {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    localparam logic [ELEM_WIDTH-1:0] SAT_MIN = {1'b1, {(ELEM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2
    } acc_state_e;

    // One extra sum bit exposes overflow: the top two bits differ exactly when the lane wrapped.
    function automatic logic [ELEM_WIDTH-1:0] sat_add_lane(
        input logic [ELEM_WIDTH-1:0] a,
        input logic [ELEM_WIDTH-1:0] b
    );
        logic [ELEM_WIDTH:0] sum;
        sum = {a[ELEM_WIDTH-1], a} + {b[ELEM_WIDTH-1], b};
        if (sum[ELEM_WIDTH] != sum[ELEM_WIDTH-1]) begin
            if (sum[ELEM_WIDTH]) begin
                sat_add_lane = SAT_MIN;
            end else begin
                sat_add_lane = SAT_MAX;
            end
        end else begin
            sat_add_lane = sum[ELEM_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/acc_vec_add.sv
// Lane-wise signed saturating vector adder; bypass passes the partial sum
// through unchanged so a first contribution overwrites the entry.
module acc_vec_add
    import acc_pkg::*;
(
    input  logic [LANES*ELEM_WIDTH-1:0] ps_vec,
    input  logic [LANES*ELEM_WIDTH-1:0] old_vec,
    input  logic                        bypass,
    output logic [LANES*ELEM_WIDTH-1:0] sum_vec
);

    // Per-lane add or pass-through
    always_comb begin
        sum_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bypass) begin
                sum_vec[i*ELEM_WIDTH +: ELEM_WIDTH] = ps_vec[i*ELEM_WIDTH +: ELEM_WIDTH];
            end else begin
                sum_vec[i*ELEM_WIDTH +: ELEM_WIDTH] =
                    sat_add_lane(ps_vec[i*ELEM_WIDTH +: ELEM_WIDTH],
                                 old_vec[i*ELEM_WIDTH +: ELEM_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator port owner: pipelined read-modify-write of partial sums and
// ranged drain to the downstream stream port with optional clear-on-read.
module acc_ctrl
    import acc_pkg::*;
#(
    parameter int VEC_WIDTH  = LANES * ELEM_WIDTH,
    parameter int ENTRY_NUM  = 16,
    parameter int ADDR_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ps_valid,
    output logic                  o_ps_ready,
    input  logic [VEC_WIDTH-1:0]  i_ps_data,
    input  logic [ADDR_WIDTH-1:0] i_ps_addr,
    input  logic                  i_ps_first,
    input  logic                  i_drain_start,
    input  logic [ADDR_WIDTH-1:0] i_drain_base,
    input  logic [ADDR_WIDTH:0]   i_drain_len,
    input  logic                  i_drain_clear,
    output logic                  o_busy,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [VEC_WIDTH-1:0]  o_out_data,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic                  o_drain_done,
    output logic                  o_acc_we,
    output logic [ADDR_WIDTH-1:0] o_acc_addr_wr,
    output logic [VEC_WIDTH-1:0]  o_acc_data_wr,
    output logic [ADDR_WIDTH-1:0] o_acc_addr_rd,
    input  logic [VEC_WIDTH-1:0]  i_acc_data_rd
);

    acc_state_e            state_r;
    acc_state_e            next_state_s;

    logic                  s1_valid_r;
    logic [ADDR_WIDTH-1:0] s1_addr_r;
    logic [VEC_WIDTH-1:0]  s1_data_r;

    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic                  clear_r;

    logic                  busy_r;
    logic                  done_r;
    logic                  out_valid_r;
    logic [VEC_WIDTH-1:0]  out_data_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;

    logic                  ps_ready_s;
    logic                  accept_s;
    logic                  start_s;
    logic                  finish_s;
    logic                  load_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic [VEC_WIDTH-1:0]  old_vec_s;
    logic [VEC_WIDTH-1:0]  sum_vec_s;

    logic                  acc_we_s;
    logic [ADDR_WIDTH-1:0] acc_addr_wr_s;
    logic [VEC_WIDTH-1:0]  acc_data_wr_s;
    logic [ADDR_WIDTH-1:0] acc_addr_rd_s;

    // Entry count is a power of two, so truncation gives the wrap past the last entry.
    assign cur_addr_s = base_r + cnt_r[ADDR_WIDTH-1:0];
    assign accept_s   = ps_ready_s & i_ps_valid;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= S_ACC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        next_state_s = state_r;
        ps_ready_s   = 1'b0;
        start_s      = 1'b0;
        finish_s     = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            S_ACC: begin
                ps_ready_s = 1'b1;
                if (i_drain_start) begin
                    start_s      = 1'b1;
                    next_state_s = S_FLUSH;
                end else begin
                    next_state_s = S_ACC;
                end
            end
            S_FLUSH: begin
                if (s1_valid_r) begin
                    next_state_s = S_FLUSH;
                end else if (len_r == '0) begin
                    finish_s     = 1'b1;
                    next_state_s = S_ACC;
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_r < len_r) begin
                    load_s       = !out_valid_r || i_out_ready;
                    next_state_s = S_DRAIN;
                end else if (!out_valid_r || i_out_ready) begin
                    finish_s     = 1'b1;
                    next_state_s = S_ACC;
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            default: begin
                next_state_s = S_ACC;
            end
        endcase
    end

    // Forward the in-flight stage-1 result when it targets the entry being read
    always_comb begin
        if (s1_valid_r && (s1_addr_r == i_ps_addr)) begin
            old_vec_s = s1_data_r;
        end else begin
            old_vec_s = i_acc_data_rd;
        end
    end

    acc_vec_add u_vec_add (
        .ps_vec  (i_ps_data),
        .old_vec (old_vec_s),
        .bypass  (i_ps_first),
        .sum_vec (sum_vec_s)
    );

    // Stage-1 pipeline register feeding the write port
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_addr_r <= i_ps_addr;
                s1_data_r <= sum_vec_s;
            end
        end
    end

    // Accumulator port ownership: stage-1 writes outside drain, clear writes inside it
    always_comb begin
        acc_addr_rd_s = i_ps_addr;
        acc_we_s      = 1'b0;
        acc_addr_wr_s = '0;
        acc_data_wr_s = '0;
        if (state_r == S_DRAIN) begin
            acc_addr_rd_s = cur_addr_s;
            acc_we_s      = load_s & clear_r;
            acc_addr_wr_s = cur_addr_s;
            acc_data_wr_s = '0;
        end else begin
            acc_addr_rd_s = i_ps_addr;
            acc_we_s      = s1_valid_r;
            acc_addr_wr_s = s1_addr_r;
            acc_data_wr_s = s1_data_r;
        end
    end

    // Drain command latch, beat counter and stream output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            base_r      <= '0;
            len_r       <= '0;
            clear_r     <= 1'b0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_addr_r  <= '0;
        end else begin
            done_r <= finish_s;
            if (start_s) begin
                base_r  <= i_drain_base;
                len_r   <= i_drain_len;
                clear_r <= i_drain_clear;
                cnt_r   <= '0;
                busy_r  <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end
            if (load_s) begin
                cnt_r       <= cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                out_valid_r <= 1'b1;
                out_data_r  <= i_acc_data_rd;
                out_addr_r  <= cur_addr_s;
            end else if (out_valid_r && i_out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign o_ps_ready    = ps_ready_s;
    assign o_busy        = busy_r;
    assign o_drain_done  = done_r;
    assign o_out_valid   = out_valid_r;
    assign o_out_data    = out_data_r;
    assign o_out_addr    = out_addr_r;
    assign o_acc_we      = acc_we_s;
    assign o_acc_addr_wr = acc_addr_wr_s;
    assign o_acc_data_wr = acc_data_wr_s;
    assign o_acc_addr_rd = acc_addr_rd_s;

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl with a behavioural 16x384 accumulator attached
// to its read/write ports; expected values are hand-computed constants.
module tb_acc_ctrl;

    localparam int VW = 384;

    logic            clk;
    logic            i_rst_n;
    logic            i_ps_valid;
    logic            o_ps_ready;
    logic [VW-1:0]   i_ps_data;
    logic [3:0]      i_ps_addr;
    logic            i_ps_first;
    logic            i_drain_start;
    logic [3:0]      i_drain_base;
    logic [4:0]      i_drain_len;
    logic            i_drain_clear;
    logic            o_busy;
    logic            o_out_valid;
    logic            i_out_ready;
    logic [VW-1:0]   o_out_data;
    logic [3:0]      o_out_addr;
    logic            o_drain_done;
    logic            o_acc_we;
    logic [3:0]      o_acc_addr_wr;
    logic [VW-1:0]   o_acc_data_wr;
    logic [3:0]      o_acc_addr_rd;
    logic [VW-1:0]   i_acc_data_rd;

    logic [VW-1:0]   mem [16] = '{default: '0};
    logic [3:0]      exp_a [4];
    logic [VW-1:0]   exp_d [4];

    int n_checks = 0;
    int n_errors = 0;

    acc_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_ps_valid    (i_ps_valid),
        .o_ps_ready    (o_ps_ready),
        .i_ps_data     (i_ps_data),
        .i_ps_addr     (i_ps_addr),
        .i_ps_first    (i_ps_first),
        .i_drain_start (i_drain_start),
        .i_drain_base  (i_drain_base),
        .i_drain_len   (i_drain_len),
        .i_drain_clear (i_drain_clear),
        .o_busy        (o_busy),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_out_addr    (o_out_addr),
        .o_drain_done  (o_drain_done),
        .o_acc_we      (o_acc_we),
        .o_acc_addr_wr (o_acc_addr_wr),
        .o_acc_data_wr (o_acc_data_wr),
        .o_acc_addr_rd (o_acc_addr_rd),
        .i_acc_data_rd (i_acc_data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_acc_we) mem[o_acc_addr_wr] <= o_acc_data_wr;
    end
    assign i_acc_data_rd = mem[o_acc_addr_rd];

    task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] splat(input logic [23:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*24 +: 24] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] lane01(input logic [23:0] l0, input logic [23:0] l1);
        logic [VW-1:0] r;
        r = '0;
        r[23:0]  = l0;
        r[47:24] = l1;
        return r;
    endfunction

    task automatic send_ps(input logic [3:0] a, input logic first, input logic [VW-1:0] d);
        @(negedge clk);
        i_ps_valid = 1'b1;
        i_ps_addr  = a;
        i_ps_first = first;
        i_ps_data  = d;
    endtask

    task automatic idle();
        @(negedge clk);
        i_ps_valid = 1'b0;
    endtask

    // Issue a drain, follow the stream for a fixed window and score every beat.
    task automatic run_drain(input logic [3:0] base, input logic [4:0] len, input logic clr,
                             input logic [31:0] rdy_pat, input logic full_rate,
                             input logic with_ps, input logic [3:0] ps_a, input logic [VW-1:0] ps_d);
        int beats = 0;
        int dones = 0;
        int done_cyc = -1;
        int first_cyc = -1;
        int last_cyc = -1;
        @(negedge clk);
        i_drain_base  = base;
        i_drain_len   = len;
        i_drain_clear = clr;
        i_drain_start = 1'b1;
        if (with_ps) begin
            i_ps_valid = 1'b1;
            i_ps_addr  = ps_a;
            i_ps_first = 1'b1;
            i_ps_data  = ps_d;
        end
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            i_drain_start = 1'b0;
            i_ps_valid    = 1'b0;
            if (o_drain_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0) begin
                check_val("busy_during_drain", o_busy, 1'b1);
                check_val("ps_ready_during_drain", o_ps_ready, 1'b0);
            end
            i_out_ready = rdy_pat[cyc];
            if (o_out_valid) begin
                if (beats < int'(len)) begin
                    check_val("out_addr", o_out_addr, exp_a[beats]);
                    check_val("out_data", o_out_data, exp_d[beats]);
                end else begin
                    check_val("extra_out_valid", o_out_valid, 1'b0);
                end
                if (i_out_ready) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats++;
                end
            end
        end
        check_val("beat_count", beats, len);
        check_val("done_count", dones, 1);
        check_val("ps_ready_after_done", o_ps_ready, 1'b1);
        check_val("busy_after_done", o_busy, 1'b0);
        if (len == 5'd0) begin
            check_val("len0_done_latency", (done_cyc >= 0 && done_cyc <= 1), 1'b1);
        end else if (full_rate) begin
            check_val("beats_consecutive", last_cyc - first_cyc, int'(len) - 1);
            check_val("done_after_last", done_cyc, last_cyc + 1);
        end
        i_out_ready = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_ps_valid = 1'b0; i_ps_data = '0; i_ps_addr = 4'd0; i_ps_first = 1'b0;
        i_drain_start = 1'b0; i_drain_base = 4'd0; i_drain_len = 5'd0; i_drain_clear = 1'b0;
        i_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_out_valid", o_out_valid, 1'b0);
        check_val("rst_done", o_drain_done, 1'b0);
        check_val("rst_acc_we", o_acc_we, 1'b0);
        check_val("rst_ps_ready", o_ps_ready, 1'b1);
        check_val("rst_acc_data_wr", o_acc_data_wr, '0);
        check_val("rst_out_data", o_out_data, '0);

        // Back-to-back same-address accumulate: 5 then 5+7 via forwarding
        send_ps(4'd3, 1'b1, splat(24'd5));
        #1 check_val("rd_addr_ps", o_acc_addr_rd, 4'd3);
        send_ps(4'd3, 1'b0, splat(24'd7));
        check_val("wr_first_we", o_acc_we, 1'b1);
        check_val("wr_first_addr", o_acc_addr_wr, 4'd3);
        check_val("wr_first_data", o_acc_data_wr, splat(24'd5));
        idle();
        check_val("wr_fwd_data", o_acc_data_wr, splat(24'd12));
        idle();
        check_val("wr_idle_we", o_acc_we, 1'b0);
        check_val("entry3", mem[3], splat(24'd12));

        // Positive saturation (forwarded) and ordinary signed add on lane 1
        send_ps(4'd5, 1'b1, lane01(24'h7FFFF0, 24'd10));
        send_ps(4'd5, 1'b0, lane01(24'h000100, 24'hFFFFFD));
        idle();
        check_val("sat_pos", o_acc_data_wr, lane01(24'h7FFFFF, 24'd7));

        // Negative saturation through the memory read path
        send_ps(4'd6, 1'b1, lane01(24'h800010, 24'hFFFFF0));
        idle();
        idle();
        send_ps(4'd6, 1'b0, lane01(24'hFFFF00, 24'h000020));
        #1 check_val("rd_addr_neg", o_acc_addr_rd, 4'd6);
        idle();
        check_val("sat_neg", o_acc_data_wr, lane01(24'h800000, 24'h000010));

        // Prefill drain targets
        send_ps(4'd14, 1'b1, splat(24'h00010E));
        send_ps(4'd15, 1'b1, splat(24'h00010F));
        send_ps(4'd0,  1'b1, splat(24'h000100));
        send_ps(4'd1,  1'b1, splat(24'h000101));
        send_ps(4'd2,  1'b1, splat(24'h000222));
        send_ps(4'd4,  1'b1, splat(24'h000444));
        idle();
        idle();

        // Wrapping drain with clear at full rate
        exp_a[0] = 4'd14; exp_d[0] = splat(24'h00010E);
        exp_a[1] = 4'd15; exp_d[1] = splat(24'h00010F);
        exp_a[2] = 4'd0;  exp_d[2] = splat(24'h000100);
        exp_a[3] = 4'd1;  exp_d[3] = splat(24'h000101);
        run_drain(4'd14, 5'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd0, '0);
        check_val("clr14", mem[14], '0);
        check_val("clr15", mem[15], '0);
        check_val("clr0", mem[0], '0);
        check_val("clr1", mem[1], '0);

        // Backpressured drain, no clear
        exp_a[0] = 4'd2; exp_d[0] = splat(24'h000222);
        exp_a[1] = 4'd3; exp_d[1] = splat(24'd12);
        exp_a[2] = 4'd4; exp_d[2] = splat(24'h000444);
        exp_a[3] = 4'd5; exp_d[3] = lane01(24'h7FFFFF, 24'd7);
        run_drain(4'd2, 5'd4, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 4'd0, '0);
        check_val("noclr3", mem[3], splat(24'd12));

        // Psum accepted in the drain-start cycle lands before the first read
        exp_a[0] = 4'd7; exp_d[0] = splat(24'd9);
        run_drain(4'd7, 5'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd7, splat(24'd9));

        // Empty drain
        run_drain(4'd9, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd0, '0);

        // Reset in the middle of a stalled drain
        @(negedge clk);
        i_drain_base = 4'd0; i_drain_len = 5'd4; i_drain_clear = 1'b0; i_drain_start = 1'b1;
        i_out_ready = 1'b0;
        @(negedge clk);
        i_drain_start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_valid", o_out_valid, 1'b1);
        i_rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_valid", o_out_valid, 1'b0);
        check_val("mid_rst_busy", o_busy, 1'b0);
        check_val("mid_rst_done", o_drain_done, 1'b0);
        check_val("mid_rst_we", o_acc_we, 1'b0);
        check_val("mid_rst_out_data", o_out_data, '0);
        check_val("mid_rst_ready", o_ps_ready, 1'b1);
        i_rst_n = 1'b1;
        i_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_val("post_rst_no_done", o_drain_done, 1'b0);
            check_val("post_rst_no_valid", o_out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
